// File: rtl/mpram_nwmr.sv
// N-write/M-read RAM: one bank per write agent, a live value table picks the bank holding the newest word.
// Read data RD_LATENCY (1 or 2) cycles after rden; every port accepts a command every cycle, no backpressure.
module mpram_nwmr #(
  parameter int NB_WRAGENT  = 4,
  parameter int NB_RDAGENT  = 3,
  parameter int ADDR_WIDTH  = 4,
  parameter int RAM_DEPTH   = 2**ADDR_WIDTH,
  parameter int DATA_WIDTH  = 8,
  parameter int WR_PRIORITY = 0,
  parameter int RDW_MODE    = 0,
  parameter int RD_LATENCY  = 1
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NB_WRAGENT-1:0]            wren,
  input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
  input  logic [NB_WRAGENT*DATA_WIDTH-1:0] wrdata,
  output logic [NB_WRAGENT-1:0]            wrcollision,
  input  logic [NB_RDAGENT-1:0]            rden,
  input  logic [NB_RDAGENT*ADDR_WIDTH-1:0] rdaddr,
  output logic [NB_RDAGENT*DATA_WIDTH-1:0] rddata,
  output logic [NB_RDAGENT-1:0]            rdvalid,
  output logic [NB_RDAGENT*2-1:0]          rdcollision
);

  localparam int SEL_W = (NB_WRAGENT > 1) ? $clog2(NB_WRAGENT) : 1;

  logic [DATA_WIDTH-1:0] bank [NB_WRAGENT][RAM_DEPTH];
  logic [SEL_W-1:0]      lvt  [RAM_DEPTH];

  logic [ADDR_WIDTH-1:0] wa [NB_WRAGENT];
  logic [DATA_WIDTH-1:0] wd [NB_WRAGENT];
  logic [NB_WRAGENT-1:0] wr_ok;
  logic [NB_WRAGENT-1:0] wr_lost;

  logic [ADDR_WIDTH-1:0] ra      [NB_RDAGENT];
  logic                  rd_hit  [NB_RDAGENT];
  logic                  rd_coll [NB_RDAGENT];
  logic [DATA_WIDTH-1:0] rd_fwd  [NB_RDAGENT];
  logic [DATA_WIDTH-1:0] rd_next [NB_RDAGENT];

  logic [NB_RDAGENT-1:0]            r1_vld;
  logic [NB_RDAGENT*DATA_WIDTH-1:0] r1_dat;
  logic [NB_RDAGENT*2-1:0]          r1_col;

  // Writes presented while in reset are discarded, including the bank update.
  always_comb begin
    for (int i = 0; i < NB_WRAGENT; i++) begin
      wa[i]    = wraddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wd[i]    = wrdata[i*DATA_WIDTH +: DATA_WIDTH];
      wr_ok[i] = aresetn && wren[i] && (int'(wa[i]) < RAM_DEPTH);
    end
  end

  always_comb begin
    for (int i = 0; i < NB_WRAGENT; i++) begin
      wr_lost[i] = 1'b0;
      for (int j = 0; j < NB_WRAGENT; j++) begin
        if (j != i && wr_ok[i] && wr_ok[j] && wa[j] == wa[i] &&
            ((WR_PRIORITY == 0) ? (j < i) : (j > i)))
          wr_lost[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NB_RDAGENT; p++) begin
      ra[p]      = rdaddr[p*ADDR_WIDTH +: ADDR_WIDTH];
      rd_hit[p]  = 1'b0;
      rd_coll[p] = 1'b0;
      rd_fwd[p]  = '0;
      for (int i = 0; i < NB_WRAGENT; i++) begin
        if (wr_ok[i] && wa[i] == ra[p]) begin
          rd_hit[p] = 1'b1;
          if (wr_lost[i]) rd_coll[p] = 1'b1;
          else            rd_fwd[p]  = wd[i];
        end
      end
      if (int'(ra[p]) >= RAM_DEPTH)
        rd_next[p] = '0;
      else if (RDW_MODE == 1 && rd_hit[p])
        rd_next[p] = rd_fwd[p];
      else
        rd_next[p] = bank[lvt[ra[p]]][ra[p]];
    end
  end

  // Losing agents still write their own bank; the LVT keeps them invisible.
  always_ff @(posedge aclk) begin
    for (int i = 0; i < NB_WRAGENT; i++) begin
      if (wr_ok[i]) bank[i][wa[i]] <= wd[i];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int a = 0; a < RAM_DEPTH; a++) lvt[a] <= '0;
      wrcollision <= '0;
      r1_vld      <= '0;
      r1_dat      <= '0;
      r1_col      <= '0;
    end else begin
      for (int i = 0; i < NB_WRAGENT; i++) begin
        if (wr_ok[i] && !wr_lost[i]) lvt[wa[i]] <= SEL_W'(i);
      end
      wrcollision <= wr_lost;
      for (int p = 0; p < NB_RDAGENT; p++) begin
        r1_vld[p]        <= rden[p];
        r1_col[p*2 +: 2] <= rden[p] ? {rd_coll[p], rd_hit[p]} : 2'b00;
        if (rden[p]) r1_dat[p*DATA_WIDTH +: DATA_WIDTH] <= rd_next[p];
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [NB_RDAGENT-1:0]            r2_vld;
      logic [NB_RDAGENT*DATA_WIDTH-1:0] r2_dat;
      logic [NB_RDAGENT*2-1:0]          r2_col;

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          r2_vld <= '0;
          r2_dat <= '0;
          r2_col <= '0;
        end else begin
          r2_vld <= r1_vld;
          r2_col <= r1_col;
          for (int p = 0; p < NB_RDAGENT; p++) begin
            if (r1_vld[p]) r2_dat[p*DATA_WIDTH +: DATA_WIDTH] <= r1_dat[p*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end

      assign rdvalid     = r2_vld;
      assign rddata      = r2_dat;
      assign rdcollision = r2_col;
    end else begin : g_lat1
      assign rdvalid     = r1_vld;
      assign rddata      = r1_dat;
      assign rdcollision = r1_col;
    end
  endgenerate

endmodule

// File: tb/tb_mpram_nwmr.sv
// Drives three mpram_nwmr configurations with identical stimulus and checks each against a visible-value model.
module tb_mpram_nwmr;

  localparam int NC = 3;
  localparam int WPS  [NC] = '{0, 1, 0};
  localparam int RDWS [NC] = '{0, 1, 1};
  localparam int LATS [NC] = '{1, 2, 1};

  logic        aclk;
  logic        aresetn;
  logic [3:0]  wren;
  logic [15:0] wraddr;
  logic [31:0] wrdata;
  logic [2:0]  rden;
  logic [11:0] rdaddr;

  logic [3:0]  wrc [NC];
  logic [23:0] rdd [NC];
  logic [2:0]  rdv [NC];
  logic [5:0]  rdc [NC];

  for (genvar g = 0; g < NC; g++) begin : g_dut
    mpram_nwmr #(
      .NB_WRAGENT(4), .NB_RDAGENT(3), .ADDR_WIDTH(4), .RAM_DEPTH(16), .DATA_WIDTH(8),
      .WR_PRIORITY(WPS[g]), .RDW_MODE(RDWS[g]), .RD_LATENCY(LATS[g])
    ) u_dut (
      .aclk(aclk), .aresetn(aresetn),
      .wren(wren), .wraddr(wraddr), .wrdata(wrdata), .wrcollision(wrc[g]),
      .rden(rden), .rdaddr(rdaddr), .rddata(rdd[g]), .rdvalid(rdv[g]), .rdcollision(rdc[g])
    );
  end

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outputs of one configuration after one clock edge.
  typedef struct packed {
    logic [2:0]  vld;
    logic [23:0] data;
    logic [2:0]  dk;
    logic [5:0]  coll;
    logic [3:0]  wrc;
  } out_t;

  logic [7:0] vis [NC][16];
  bit         vk  [NC][16];
  logic [7:0] b0  [16];
  bit         b0k [16];
  logic [7:0] ld  [NC][3];
  bit         lk  [NC][3];
  out_t       cur [NC];
  out_t       prev[NC];

  typedef struct {
    logic [3:0]  wren;
    logic [15:0] wraddr;
    logic [31:0] wrdata;
    logic [2:0]  rden;
    logic [11:0] rdaddr;
    int          port;
    logic        exp_vld;
    bit          chk_a;
    logic [7:0]  exp_a;
    logic [7:0]  exp_c;
    logic [1:0]  exp_col;
    logic [3:0]  exp_wrc;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      for (int a = 0; a < 16; a++) begin
        vis[c][a] = b0[a];
        vk[c][a]  = b0k[a];
      end
      for (int p = 0; p < 3; p++) begin
        ld[c][p] = 8'h00;
        lk[c][p] = 1'b1;
      end
      cur[c]    = '0;
      cur[c].dk = 3'b111;
      prev[c]   = cur[c];
    end
  endtask

  // Resolves the current inputs against the word each address shows to readers.
  task automatic model_eval();
    int win [16];
    int cnt [16];
    logic [3:0] a;
    for (int c = 0; c < NC; c++) begin
      out_t o;
      o = '0;
      for (int x = 0; x < 16; x++) begin
        win[x] = -1;
        cnt[x] = 0;
      end
      for (int i = 0; i < 4; i++) begin
        if (wren[i]) begin
          a = wraddr[i*4 +: 4];
          cnt[a]++;
          if (win[a] < 0 || WPS[c] == 1) win[a] = i;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (wren[i] && win[wraddr[i*4 +: 4]] != i) o.wrc[i] = 1'b1;
      end
      for (int p = 0; p < 3; p++) begin
        if (rden[p]) begin
          a = rdaddr[p*4 +: 4];
          o.vld[p] = 1'b1;
          o.coll[p*2 +: 2] = {cnt[a] > 1, cnt[a] > 0};
          if (RDWS[c] == 1 && cnt[a] > 0) begin
            ld[c][p] = wrdata[win[a]*8 +: 8];
            lk[c][p] = 1'b1;
          end else begin
            ld[c][p] = vis[c][a];
            lk[c][p] = vk[c][a];
          end
        end
        o.data[p*8 +: 8] = ld[c][p];
        o.dk[p]          = lk[c][p];
      end
      for (int x = 0; x < 16; x++) begin
        if (cnt[x] > 0) begin
          vis[c][x] = wrdata[win[x]*8 +: 8];
          vk[c][x]  = 1'b1;
        end
      end
      prev[c] = cur[c];
      cur[c]  = o;
    end
    if (wren[0]) begin
      b0[wraddr[3:0]]  = wrdata[7:0];
      b0k[wraddr[3:0]] = 1'b1;
    end
  endtask

  task automatic check_dut();
    out_t e;
    for (int c = 0; c < NC; c++) begin
      e = (LATS[c] == 1) ? cur[c] : prev[c];
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("cfg%0d_rdvalid%0d", c, p), rdv[c][p], e.vld[p]);
        chk($sformatf("cfg%0d_rdcoll%0d", c, p), rdc[c][p*2 +: 2], e.coll[p*2 +: 2]);
        if (e.dk[p]) chk($sformatf("cfg%0d_rddata%0d", c, p), rdd[c][p*8 +: 8], e.data[p*8 +: 8]);
      end
      chk($sformatf("cfg%0d_wrcoll", c), wrc[c], cur[c].wrc);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("%s_cfg%0d_rddata", tag, c), rdd[c], 24'h0);
      chk($sformatf("%s_cfg%0d_rdvalid", tag, c), rdv[c], 3'h0);
      chk($sformatf("%s_cfg%0d_rdcoll", tag, c), rdc[c], 6'h0);
      chk($sformatf("%s_cfg%0d_wrcoll", tag, c), wrc[c], 4'h0);
    end
  endtask

  task automatic step();
    model_eval();
    @(posedge aclk);
    #1;
    check_dut();
  endtask

  task automatic rand_wr();
    wren   = 4'($urandom);
    wraddr = 16'($urandom);
    wrdata = $urandom;
  endtask

  initial begin
    tbl[0] = '{4'b0100, 16'h0500, 32'h00A5_0000, 3'b000, 12'h000, 0, 1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 4'b0000};
    tbl[1] = '{4'b0000, 16'h0000, 32'h0000_0000, 3'b001, 12'h005, 0, 1'b1, 1'b1, 8'hA5, 8'hA5, 2'b00, 4'b0000};
    tbl[2] = '{4'b1001, 16'h7007, 32'h3300_0011, 3'b000, 12'h000, 0, 1'b0, 1'b1, 8'hA5, 8'hA5, 2'b00, 4'b1000};
    tbl[3] = '{4'b0000, 16'h0000, 32'h0000_0000, 3'b001, 12'h007, 0, 1'b1, 1'b1, 8'h11, 8'h11, 2'b00, 4'b0000};
    tbl[4] = '{4'b0010, 16'h0020, 32'h0000_2000, 3'b000, 12'h000, 1, 1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 4'b0000};
    tbl[5] = '{4'b0010, 16'h0020, 32'h0000_2100, 3'b010, 12'h020, 1, 1'b1, 1'b1, 8'h20, 8'h21, 2'b01, 4'b0000};
    tbl[6] = '{4'b0011, 16'h0099, 32'h0000_9190, 3'b100, 12'h900, 2, 1'b1, 1'b0, 8'h00, 8'h90, 2'b11, 4'b0010};
    tbl[7] = '{4'b0000, 16'h0000, 32'h0000_0000, 3'b100, 12'h900, 2, 1'b1, 1'b1, 8'h90, 8'h90, 2'b00, 4'b0000};
    tbl[8] = '{4'b0000, 16'h0000, 32'h0000_0000, 3'b000, 12'h000, 2, 1'b0, 1'b1, 8'h90, 8'h90, 2'b00, 4'b0000};

    for (int a = 0; a < 16; a++) begin
      b0[a]  = 8'h00;
      b0k[a] = 1'b0;
    end
    wren = '0; wraddr = '0; wrdata = '0; rden = '0; rdaddr = '0;
    aresetn = 1'b1;
    #1 aresetn = 1'b0;
    #11 check_zero("reset");
    @(negedge aclk);
    aresetn = 1'b1;
    model_reset();
    @(posedge aclk);
    #1;

    // Directed rows with hand-derived results for configs 0 (old data) and 2 (forwarding).
    for (int r = 0; r < 9; r++) begin
      int p;
      wren = tbl[r].wren; wraddr = tbl[r].wraddr; wrdata = tbl[r].wrdata;
      rden = tbl[r].rden; rdaddr = tbl[r].rdaddr;
      step();
      p = tbl[r].port;
      chk($sformatf("row%0d_vld_a", r), rdv[0][p], tbl[r].exp_vld);
      chk($sformatf("row%0d_vld_c", r), rdv[2][p], tbl[r].exp_vld);
      if (tbl[r].chk_a) chk($sformatf("row%0d_data_a", r), rdd[0][p*8 +: 8], tbl[r].exp_a);
      chk($sformatf("row%0d_data_c", r), rdd[2][p*8 +: 8], tbl[r].exp_c);
      chk($sformatf("row%0d_coll_a", r), rdc[0][p*2 +: 2], tbl[r].exp_col);
      chk($sformatf("row%0d_coll_c", r), rdc[2][p*2 +: 2], tbl[r].exp_col);
      chk($sformatf("row%0d_wrc_a", r), wrc[0], tbl[r].exp_wrc);
      chk($sformatf("row%0d_wrc_c", r), wrc[2], tbl[r].exp_wrc);
    end

    // Agent 0 fills every word so all later reads have defined data.
    for (int k = 0; k < 16; k++) begin
      wren = 4'b0001; wraddr = {12'h000, 4'(k)}; wrdata = {24'h0, 8'($urandom)};
      rden = 3'b000; rdaddr = '0;
      step();
    end

    for (int k = 0; k < 300; k++) begin
      rand_wr();
      rden   = 3'($urandom);
      rdaddr = 12'($urandom);
      step();
    end

    for (int k = 0; k < 16; k++) begin
      rand_wr();
      rden   = 3'b111;
      rdaddr = {4'((k + 10) % 16), 4'((k + 5) % 16), 4'(k)};
      step();
    end

    // Reset lands while a full read/write burst is being presented.
    rand_wr();
    wren = 4'b1111;
    rden = 3'b111;
    #2 aresetn = 1'b0;
    #1 check_zero("rst_async");
    @(posedge aclk);
    #1 check_zero("rst_held");
    #2 aresetn = 1'b1;
    model_reset();

    for (int k = 0; k < 16; k++) begin
      wren = '0; wraddr = '0; wrdata = '0;
      rden = 3'b001; rdaddr = {8'h00, 4'(k)};
      step();
    end

    for (int k = 0; k < 100; k++) begin
      rand_wr();
      rden   = 3'($urandom);
      rdaddr = 12'($urandom);
      step();
    end

    wren = '0; rden = '0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mpram_nwmr.md
Name: mpram_nwmr

Overview:
- Generalised multi-port RAM with N write ports and M read ports; successor to the fixed 2W/2R memory top.
- One replicated bank per write agent plus an internal Live Value Table (LVT) that records which bank last wrote each address; read ports mux the bank selected by the LVT.
- Adds configurable write-collision priority, read-during-write mode, read latency, per-port valid and collision flags.
- Sits between agent-side bus adapters and shared-state consumers (descriptor tables, scoreboards).

Parameters:
- NB_WRAGENT, 4, number of write ports (>=1).
- NB_RDAGENT, 3, number of read ports (>=1).
- ADDR_WIDTH, 4, address width in bits.
- RAM_DEPTH, 2**ADDR_WIDTH, words per bank (<= 2**ADDR_WIDTH).
- DATA_WIDTH, 8, word width in bits.
- WR_PRIORITY, 0, same-address write collision winner: 0 = lowest agent index, 1 = highest.
- RDW_MODE, 0, read of an address written in the same cycle: 0 = old data, 1 = new (winning) data.
- RD_LATENCY, 1, read latency in cycles, 1 or 2 (2 adds an output register stage).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- wren  in  NB_WRAGENT  write enable per agent.
- wraddr  in  NB_WRAGENT*ADDR_WIDTH  packed write addresses, agent i at [i*ADDR_WIDTH+:ADDR_WIDTH].
- wrdata  in  NB_WRAGENT*DATA_WIDTH  packed write data.
- wrcollision  out  NB_WRAGENT  per agent: write lost a same-cycle collision, registered.
- rden  in  NB_RDAGENT  read enable per port.
- rdaddr  in  NB_RDAGENT*ADDR_WIDTH  packed read addresses.
- rddata  out  NB_RDAGENT*DATA_WIDTH  packed read data.
- rdvalid  out  NB_RDAGENT  rddata qualifier per port.
- rdcollision  out  NB_RDAGENT*2  per port: bit0 = read hit an address written that cycle, bit1 = that address also had a write collision.

Behaviour:
- Reset (aresetn low, async): LVT cleared to 0; rddata, rdvalid, rdcollision, wrcollision forced to 0; pipeline registers cleared. Bank contents are not reset, so reads of never-written addresses are undefined.
- Reset deassertion mid-operation: first edge after release accepts new commands; writes in flight during reset are dropped.
- LVT width: SEL_W = max(1, $clog2(NB_WRAGENT)); RAM_DEPTH entries.
- Write, cycle T: each enabled agent i writes wrdata[i] to bank i at wraddr[i] on the edge. The LVT entry for each written address gets the winning agent index.
- Collision: if k>1 agents target the same address in one cycle, the winner follows WR_PRIORITY. All k banks are written but only the winner is visible. Each loser's wrcollision bit is high at T+1 for exactly one cycle.
- Read latency: rden at cycle T gives rdvalid/rddata/rdcollision at T+RD_LATENCY. With rden low, rdvalid=0 and rddata holds its last value.
- Read path: lvt[rdaddr] selects bank; data = bank_sel[rdaddr] sampled at T.
- Read-during-write, same address, same cycle:
  - RDW_MODE=0: returns the pre-write value.
  - RDW_MODE=1: forwards the winning wrdata.
- rdcollision bit0 is set whenever a same-address write occurs, independent of RDW_MODE. Bit1 is set when that write was itself a collision.
- Out-of-range addresses (>= RAM_DEPTH): writes ignored (no LVT update, no collision flag); reads return 0 with rdvalid=1.
- Fully pipelined: back-to-back reads and writes every cycle; no stalls, no backpressure.

Test Plan:
- Reset, then write agent2 addr 5 = 0xA5 at T; read port0 addr 5 at T+1 -> rddata0=0xA5, rdvalid0=1 at T+2 (RD_LATENCY=1), rdcollision0=00.
- Collision: agents 0 and 3 write addr 7 (0x11, 0x33) at T, WR_PRIORITY=0 -> wrcollision=4'b1000 at T+1; later read addr 7 = 0x11. Repeat with WR_PRIORITY=1 -> wrcollision=4'b0001, read 0x33.
- RDW: addr 2 holds 0x20; agent1 writes 0x21 to addr 2 while port1 reads addr 2 -> RDW_MODE=0 returns 0x20, RDW_MODE=1 returns 0x21; rdcollision1=01 in both.
- RDW with collision: agents 0 and 1 write addr 9 (0x90, 0x91) while port2 reads addr 9, RDW_MODE=1, WR_PRIORITY=0 -> rddata2=0x90, rdcollision2=11.
- All 3 read ports read distinct addresses each cycle for 16 cycles with RD_LATENCY=2 -> data matches the reference model, rdvalid delayed exactly 2 cycles, no gaps.
- Assert aresetn mid-burst -> all outputs 0 asynchronously; after release, a read of a previously written addr returns bank0 contents (LVT=0).
